// File: rtl/al_unit_pkg.sv
// Shared definitions for the ALU: opcode constants used by the control unit
// and the shifter mode encoding.
package al_unit_pkg;

  localparam int DATA_W = 32;
  localparam int SHAMT_W = 5;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_LUI  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1100;
  localparam logic [3:0] ALU_SRA  = 4'b1110;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10
  } shift_mode_e;

endpackage

// File: rtl/al_unit_shifter.sv
// Purely combinational 32-bit barrel shifter: logical left, logical right,
// arithmetic right.
module al_shifter
  import al_unit_pkg::*;
(
  input  logic [DATA_W-1:0]  value,
  input  logic [SHAMT_W-1:0] shamt,
  input  shift_mode_e        mode,
  output logic [DATA_W-1:0]  result
);

  logic signed [DATA_W-1:0] value_s;

  assign value_s = $signed(value);

  always_comb begin
    result = '0;
    case (mode)
      SH_SLL:  result = value << shamt;
      SH_SRL:  result = value >> shamt;
      SH_SRA:  result = $unsigned(value_s >>> shamt);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/al_unit.sv
// Single-cycle ALU: next result is computed combinationally and registered
// together with its zero flag on every rising edge.
module al_unit
  import al_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_ra,
  input  logic [31:0] alu_rb,
  input  logic [3:0]  cu_aluc,
  output logic [31:0] alu_result,
  output logic        alu_zero
);

  logic signed [DATA_W-1:0] ra_s_p0;
  logic signed [DATA_W-1:0] rb_s_p0;
  logic [DATA_W-1:0]        shift_p0;
  logic [DATA_W-1:0]        next_p0;
  shift_mode_e              mode_p0;
  logic [DATA_W-1:0]        result_p1;
  logic                     zero_p1;

  assign ra_s_p0 = $signed(alu_ra);
  assign rb_s_p0 = $signed(alu_rb);

  always_comb begin
    mode_p0 = SH_SLL;
    case (cu_aluc)
      ALU_SRL: mode_p0 = SH_SRL;
      ALU_SRA: mode_p0 = SH_SRA;
      default: mode_p0 = SH_SLL;
    endcase
  end

  // Only ra[4:0] feeds the shift amount; the shifted value comes from rb.
  al_shifter u_shifter (
    .value  (alu_rb),
    .shamt  (alu_ra[SHAMT_W-1:0]),
    .mode   (mode_p0),
    .result (shift_p0)
  );

  always_comb begin
    next_p0 = '0;
    case (cu_aluc)
      ALU_ADD:  next_p0 = alu_ra + alu_rb;
      ALU_SUB:  next_p0 = alu_ra - alu_rb;
      ALU_AND:  next_p0 = alu_ra & alu_rb;
      ALU_OR:   next_p0 = alu_ra | alu_rb;
      ALU_XOR:  next_p0 = alu_ra ^ alu_rb;
      ALU_NOR:  next_p0 = ~(alu_ra | alu_rb);
      ALU_SLT:  next_p0 = {{(DATA_W-1){1'b0}}, (ra_s_p0 < rb_s_p0)};
      ALU_SLTU: next_p0 = {{(DATA_W-1){1'b0}}, (alu_ra < alu_rb)};
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  next_p0 = shift_p0;
      ALU_LUI:  next_p0 = {alu_rb[15:0], 16'h0000};
      default:  next_p0 = '0;
    endcase
  end

  // Stage p0 -> p1: result and zero flag captured from the same next value.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_p1 <= '0;
      zero_p1   <= 1'b1;
    end else begin
      result_p1 <= next_p0;
      zero_p1   <= (next_p0 == '0);
    end
  end

  assign alu_result = result_p1;
  assign alu_zero   = zero_p1;

endmodule

// File: tb/tb_al_unit.sv
// Directed bench for al_unit: a vector table with hand-computed results plus
// short sequences for latency and reset-priority behaviour.
module tb_al_unit;

  logic        clk;
  logic        rst;
  logic [31:0] alu_ra;
  logic [31:0] alu_rb;
  logic [3:0]  cu_aluc;
  logic [31:0] alu_result;
  logic        alu_zero;

  int n_cmp;
  int n_bad;

  typedef struct {
    string       name;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [3:0]  aluc;
    logic [31:0] exp_res;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[$];

  al_unit dut (
    .clk        (clk),
    .rst        (rst),
    .alu_ra     (alu_ra),
    .alu_rb     (alu_rb),
    .cu_aluc    (cu_aluc),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ra, input logic [31:0] rb, input logic [3:0] aluc);
    @(negedge clk);
    alu_ra  = ra;
    alu_rb  = rb;
    cu_aluc = aluc;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic addv(input string name, input logic [31:0] ra, input logic [31:0] rb,
                      input logic [3:0] aluc, input logic [31:0] exp_res, input logic exp_zero);
    vec_t v;
    v.name = name; v.ra = ra; v.rb = rb; v.aluc = aluc;
    v.exp_res = exp_res; v.exp_zero = exp_zero;
    vecs.push_back(v);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    addv("add",       32'h0000000F, 32'h8000000C, 4'b0000, 32'h8000001B, 1'b0);
    addv("sra15",     32'h0000000F, 32'h8000000C, 4'b1110, 32'hFFFF0000, 1'b0);
    addv("srl15",     32'h0000000F, 32'h8000000C, 4'b1100, 32'h00010000, 1'b0);
    addv("sll15",     32'h0000000F, 32'h8000000C, 4'b1000, 32'h00060000, 1'b0);
    addv("sub_zero",  32'h00000005, 32'h00000005, 4'b0001, 32'h00000000, 1'b1);
    addv("add_wrap",  32'hFFFFFFFF, 32'h00000001, 4'b0000, 32'h00000000, 1'b1);
    addv("slt_neg",   32'hFFFFFFFF, 32'h00000001, 4'b0110, 32'h00000001, 1'b0);
    addv("sltu_big",  32'hFFFFFFFF, 32'h00000001, 4'b0111, 32'h00000000, 1'b1);
    addv("slt_pos",   32'h00000005, 32'hFFFFFFFB, 4'b0110, 32'h00000000, 1'b1);
    addv("sltu_pos",  32'h00000005, 32'hFFFFFFFB, 4'b0111, 32'h00000001, 1'b0);
    addv("sub_wrap",  32'h00000000, 32'h00000001, 4'b0001, 32'hFFFFFFFF, 1'b0);
    addv("and",       32'hF0F01234, 32'h0FF0FF00, 4'b0010, 32'h00F01200, 1'b0);
    addv("or",        32'hF0F01234, 32'h0FF0FF00, 4'b0011, 32'hFFF0FF34, 1'b0);
    addv("xor",       32'hF0F01234, 32'h0FF0FF00, 4'b0100, 32'hFF00ED34, 1'b0);
    addv("nor",       32'hF0F01234, 32'h0FF0FF00, 4'b0101, 32'h000F00CB, 1'b0);
    addv("lui",       32'hFFFFFFFF, 32'h1234ABCD, 4'b1001, 32'hABCD0000, 1'b0);
    addv("sra_sh0",   32'h00000020, 32'h80000000, 4'b1110, 32'h80000000, 1'b0);
    addv("sll_hi_ra", 32'hFFFFFFE1, 32'h40000001, 4'b1000, 32'h80000002, 1'b0);
    addv("sra31",     32'h0000001F, 32'h80000000, 4'b1110, 32'hFFFFFFFF, 1'b0);
    addv("srl31",     32'h0000001F, 32'h80000000, 4'b1100, 32'h00000001, 1'b0);
    addv("srl_sh0",   32'hFFFFFFE0, 32'h87654321, 4'b1100, 32'h87654321, 1'b0);
    addv("undef1010", 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1010, 32'h00000000, 1'b1);
    addv("undef1011", 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1011, 32'h00000000, 1'b1);
    addv("undef1101", 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1101, 32'h00000000, 1'b1);
    addv("undef1111", 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1111, 32'h00000000, 1'b1);

    // Reset for two cycles with non-zero operands on an ADD.
    rst     = 1'b1;
    alu_ra  = 32'h12345678;
    alu_rb  = 32'h11111111;
    cu_aluc = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      edge_sample();
      check32("reset_result", alu_result, 32'h0);
      check1("reset_zero", alu_zero, 1'b1);
    end

    // First edge after release registers the operation present at it.
    @(negedge clk);
    rst = 1'b0;
    edge_sample();
    check32("post_reset_add", alu_result, 32'h23456789);
    check1("post_reset_zero", alu_zero, 1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].ra, vecs[i].rb, vecs[i].aluc);
      edge_sample();
      check32({vecs[i].name, "_res"}, alu_result, vecs[i].exp_res);
      check1({vecs[i].name, "_zero"}, alu_zero, vecs[i].exp_zero);
    end

    // Exactly one-edge latency: output holds until the edge after the opcode change.
    drive(32'h0000000F, 32'h8000000C, 4'b0000);
    edge_sample();
    check32("lat_add", alu_result, 32'h8000001B);
    drive(32'h0000000F, 32'h8000000C, 4'b1110);
    #1;
    check32("lat_hold_before_edge", alu_result, 32'h8000001B);
    edge_sample();
    check32("lat_sra_after_edge", alu_result, 32'hFFFF0000);
    drive(32'h0000000F, 32'h8000000C, 4'b1100);
    #1;
    check32("lat_hold_srl", alu_result, 32'hFFFF0000);
    edge_sample();
    check32("lat_srl_after_edge", alu_result, 32'h00010000);

    // Reset asserted in the middle of an SRA stream takes priority.
    drive(32'h00000004, 32'hF0000000, 4'b1110);
    edge_sample();
    check32("sra_stream", alu_result, 32'hFF000000);
    @(negedge clk);
    rst = 1'b1;
    edge_sample();
    check32("mid_reset_result", alu_result, 32'h0);
    check1("mid_reset_zero", alu_zero, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    edge_sample();
    check32("resume_sra", alu_result, 32'hFF000000);
    check1("resume_sra_zero", alu_zero, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/al_unit.md
AL_UNIT -- requirements
Module: al_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port `clk`: input, 1 bit; rising-edge clock for all state.
REQ-003 Port `rst`: input, 1 bit; synchronous, active-high reset.
REQ-004 Port `alu_ra`: input, 32 bits; operand A, and the shift amount source for shift operations.
REQ-005 Port `alu_rb`: input, 32 bits; operand B, and the value that is shifted for shift operations.
REQ-006 Port `cu_aluc`: input, 4 bits; operation select from the control unit.
REQ-007 Port `alu_result`: output, 32 bits; registered operation result.
REQ-008 Port `alu_zero`: output, 1 bit; registered flag, 1 when the registered alu_result equals 0.

Function
REQ-009 The block SHALL compute the next result combinationally from alu_ra, alu_rb and cu_aluc, and register it on every rising clk edge.
REQ-010 Latency SHALL be exactly 1 cycle; there is no handshake or enable, and a new operation is accepted every cycle.
REQ-011 The cu_aluc encoding SHALL be:
- 0000 ADD: ra+rb
- 0001 SUB: ra-rb
- 0010 AND
- 0011 OR
- 0100 XOR
- 0101 NOR
- 0110 SLT: signed compare, result 1 if ra<rb else 0
- 0111 SLTU: unsigned compare, result 1 if ra<rb else 0
- 1000 SLL: rb<<ra[4:0]
- 1001 LUI: {rb[15:0],16'h0}
- 1100 SRL: rb>>ra[4:0], zero fill
- 1110 SRA: rb>>>ra[4:0], fill with rb[31]
REQ-012 Any other cu_aluc value (1010, 1011, 1101, 1111) SHALL produce a result of 32'h0.
REQ-013 ADD and SUB SHALL wrap modulo 2^32, with no overflow or carry output.
REQ-014 Shifts SHALL use only ra[4:0]; ra[31:5] SHALL be ignored. A shift amount of 0 SHALL pass rb through unchanged.
REQ-015 alu_zero SHALL be derived from the same next-result value and registered in the same edge as alu_result, so the two outputs are always consistent.
REQ-016 SLT/SLTU results SHALL be zero-extended to 32 bits.

Reset
REQ-017 When rst=1 at a rising clk edge, alu_result SHALL become 32'h0 and alu_zero SHALL become 1, regardless of the other inputs.
REQ-018 Reset SHALL take priority over any operation in the same cycle. The first post-reset edge with rst=0 SHALL register the operation present at that edge.

Structure
REQ-019 The cu_aluc opcode constants SHALL live in the shared package al_unit_pkg, which the control unit also imports.
REQ-020 The 32-bit barrel shifter SHALL be a sub-module named al_shifter, with inputs value[31:0], shamt[4:0] and mode (SLL/SRL/SRA), and output result[31:0]. It SHALL be purely combinational.
REQ-021 No latches are permitted; every combinational path SHALL assign a default.

Verification
REQ-022 Drive rst=1 for 2 cycles with arbitrary operands -> alu_result=0, alu_zero=1.
REQ-023 ra=32'h0000000F, rb=32'h8000000C, cu_aluc=0000 -> after one edge, alu_result=32'h8000001B, alu_zero=0.
REQ-024 With the same operands:
- cu_aluc=1110 -> 32'hFFFF0000
- cu_aluc=1100 -> 32'h00010000
- cu_aluc=1000 -> 32'h00060000
Each result SHALL appear exactly one edge after the opcode change.
REQ-025 ra=5, rb=5, cu_aluc=0001 -> result 0, alu_zero=1. ra=32'hFFFFFFFF, rb=1, cu_aluc=0000 -> result 0 (wrap), alu_zero=1.
REQ-026 ra=32'hFFFFFFFF, rb=1:
- cu_aluc=0110 (SLT) -> 1
- cu_aluc=0111 (SLTU) -> 0
REQ-027 Shift edge cases:
- ra=32'h00000020 (shamt 0), cu_aluc=1110, rb=32'h80000000 -> 32'h80000000.
- Undefined opcode 1111 -> 0, alu_zero=1.
- rst asserted mid-stream during an SRA -> 0 on the next edge.
